// File: rtl/lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
//   Leaky integrate-and-fire neuron core. One timestep request serially sums
//   the gated synaptic weights into a saturating signed membrane potential,
//   applies a shift-based leak, compares against a threshold, optionally
//   fires, and then holds off a fixed number of timesteps (refractory).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   timestep request, sampled only while idle
//   spikes_in  in   input spike vector, latched when a start is accepted
//   weight_in  in   signed weight for synapse w_idx (driven combinationally
//                   by upstream from w_idx in the same cycle)
//   w_idx      out  synapse index being integrated (0 outside integration)
//   busy       out  high from the cycle after an accepted start through done
//   done       out  one-cycle pulse at the end of a timestep
//   spike_out  out  one-cycle pulse coincident with done when the neuron fires
//   vmem       out  registered signed membrane potential
// -----------------------------------------------------------------------------
module lif_neuron #(
  parameter int N_INPUTS      = 8,
  parameter int W_WIDTH       = 8,
  parameter int V_WIDTH       = 16,
  parameter int THRESHOLD     = 100,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRACT_STEPS = 2,
  localparam int IDX_W        = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_INPUTS-1:0] spikes_in,
  input  logic [W_WIDTH-1:0]  weight_in,
  output logic [IDX_W-1:0]    w_idx,
  output logic                busy,
  output logic                done,
  output logic                spike_out,
  output logic [V_WIDTH-1:0]  vmem
);

  localparam int RC_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INTEG = 3'd1;
  localparam logic [2:0] S_LEAK  = 3'd2;
  localparam logic [2:0] S_FIRE  = 3'd3;
  localparam logic [2:0] S_REFR  = 3'd4;

  localparam logic signed [V_WIDTH-1:0] V_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH-1:0] V_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};
  localparam logic signed [V_WIDTH-1:0] THR   = V_WIDTH'(THRESHOLD);
  localparam logic [IDX_W-1:0]          LAST  = IDX_W'(N_INPUTS - 1);

  logic [2:0]                 state_q,  state_d;
  logic [N_INPUTS-1:0]        spikes_q, spikes_d;
  logic [IDX_W-1:0]           idx_q,    idx_d;
  logic signed [V_WIDTH-1:0]  vmem_q,   vmem_d;
  logic                       fire_q,   fire_d;
  logic [RC_W-1:0]            refr_q,   refr_d;

  // Datapath: one extra bit of headroom so a single add can never wrap
  // before the clamp sees it.
  logic signed [V_WIDTH:0]    sum;
  logic signed [V_WIDTH-1:0]  sum_sat;
  logic signed [V_WIDTH-1:0]  v_leak;

  always_comb begin
    sum = {vmem_q[V_WIDTH-1], vmem_q}
        + {{(V_WIDTH+1-W_WIDTH){weight_in[W_WIDTH-1]}}, weight_in};
    if (sum[V_WIDTH] != sum[V_WIDTH-1]) begin
      sum_sat = sum[V_WIDTH] ? V_MIN : V_MAX;
    end else begin
      sum_sat = sum[V_WIDTH-1:0];
    end
    // Subtracting the arithmetically shifted value always moves toward zero,
    // so no clamp is needed here.
    v_leak = vmem_q - (vmem_q >>> LEAK_SHIFT);
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first; a path that
    // leaves one unassigned would infer a latch.
    state_d  = state_q;
    spikes_d = spikes_q;
    idx_d    = '0;
    vmem_d   = vmem_q;
    fire_d   = fire_q;
    refr_d   = refr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (refr_q == '0) begin
            spikes_d = spikes_in;
            state_d  = S_INTEG;
          end else begin
            state_d  = S_REFR;
          end
        end
      end
      S_INTEG: begin
        if (spikes_q[idx_q]) begin
          vmem_d = sum_sat;
        end
        if (idx_q == LAST) begin
          state_d = S_LEAK;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_LEAK: begin
        // The fire decision is taken on the leaked value here so that the
        // membrane shown alongside done is already the final one (0 on fire).
        fire_d  = (v_leak >= THR);
        vmem_d  = (v_leak >= THR) ? '0 : v_leak;
        state_d = S_FIRE;
      end
      S_FIRE: begin
        if (fire_q) begin
          refr_d = RC_W'(REFRACT_STEPS);
        end
        fire_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_REFR: begin
        refr_d  = refr_q - 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      spikes_q <= '0;
      idx_q    <= '0;
      vmem_q   <= '0;
      fire_q   <= 1'b0;
      refr_q   <= '0;
    end else begin
      state_q  <= state_d;
      spikes_q <= spikes_d;
      idx_q    <= idx_d;
      vmem_q   <= vmem_d;
      fire_q   <= fire_d;
      refr_q   <= refr_d;
    end
  end

  assign w_idx     = idx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIRE) || (state_q == S_REFR);
  assign spike_out = (state_q == S_FIRE) && fire_q;
  assign vmem      = vmem_q;

endmodule

// File: tb/tb_lif_neuron.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron
//   Scoreboard bench for lif_neuron. Stimulus tasks push the hand-computed
//   result of each timestep into a queue; independent monitors pop and compare
//   whenever a DUT raises done. Instance a uses V_WIDTH=16, instance b uses
//   V_WIDTH=9 for the negative-saturation case.
// -----------------------------------------------------------------------------
module tb_lif_neuron;

  typedef struct {
    logic                spike;
    logic signed [15:0]  v;
    int                  lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Instance a
  logic              start_a;
  logic [3:0]        spikes_a;
  logic signed [7:0] w_a [4];
  logic [7:0]        weight_a;
  logic [1:0]        w_idx_a;
  logic              busy_a, done_a, spike_a;
  logic [15:0]       vmem_a;

  // Instance b
  logic              start_b;
  logic [3:0]        spikes_b;
  logic signed [7:0] w_b [4];
  logic [7:0]        weight_b;
  logic [1:0]        w_idx_b;
  logic              busy_b, done_b, spike_b;
  logic [8:0]        vmem_b;

  // Upstream weight mux: combinational from w_idx.
  always_comb weight_a = w_a[w_idx_a];
  always_comb weight_b = w_b[w_idx_b];

  lif_neuron #(.N_INPUTS(4), .W_WIDTH(8), .V_WIDTH(16), .THRESHOLD(100),
               .LEAK_SHIFT(3), .REFRACT_STEPS(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .spikes_in(spikes_a),
    .weight_in(weight_a), .w_idx(w_idx_a), .busy(busy_a), .done(done_a),
    .spike_out(spike_a), .vmem(vmem_a)
  );

  lif_neuron #(.N_INPUTS(4), .W_WIDTH(8), .V_WIDTH(9), .THRESHOLD(100),
               .LEAK_SHIFT(3), .REFRACT_STEPS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .spikes_in(spikes_b),
    .weight_in(weight_b), .w_idx(w_idx_b), .busy(busy_b), .done(done_b),
    .spike_out(spike_b), .vmem(vmem_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitors
  int bcnt_a = 0;
  int bcnt_b = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy_a) bcnt_a++;
      else        bcnt_a = 0;
      if (done_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q_a.pop_front();
          check("a_spike",   spike_a, e.spike);
          check("a_vmem",    $signed(vmem_a), e.v);
          check("a_latency", bcnt_a, e.lat);
        end
      end
    end else begin
      bcnt_a = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (busy_b) bcnt_b++;
      else        bcnt_b = 0;
      if (done_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          check("b_spike",   spike_b, e.spike);
          check("b_vmem",    $signed(vmem_b), e.v);
          check("b_latency", bcnt_b, e.lat);
        end
      end
    end else begin
      bcnt_b = 0;
    end
  end

  // ---------------------------------------------------------------- stimulus
  // One timestep on instance a. During busy the spike vector is inverted and,
  // when poke is set, an extra start is pulsed; neither may affect the result.
  task automatic run_a(input logic [3:0] spk, input int w0, input int w1,
                       input int w2, input int w3, input logic exp_spike,
                       input int exp_v, input int lat, input bit poke);
    exp_t e;
    bit   seen;
    e.spike = exp_spike;
    e.v     = 16'(exp_v);
    e.lat   = lat;
    @(negedge clk);
    w_a[0] = 8'(w0); w_a[1] = 8'(w1); w_a[2] = 8'(w2); w_a[3] = 8'(w3);
    spikes_a = spk;
    start_a  = 1'b1;
    q_a.push_back(e);
    @(negedge clk);
    start_a  = 1'b0;
    spikes_a = ~spk;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done_a) begin
        seen = 1'b1;
      end else begin
        start_a = poke && (i == 1);
        @(negedge clk);
      end
    end
    start_a = 1'b0;
    check("a_done_timeout", seen, 1);
  endtask

  initial begin
    bit seen;
    exp_t e;

    rst      = 1'b1;
    start_a  = 1'b1;
    start_b  = 1'b1;
    spikes_a = 4'b1111;
    spikes_b = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      w_a[i] = 8'sd50;
      w_b[i] = 8'sd50;
    end

    // Reset held 3 cycles with start high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy",  busy_a,  0);
      check("rst_done",  done_a,  0);
      check("rst_spike", spike_a, 0);
      check("rst_vmem",  vmem_a,  0);
      check("rst_widx",  w_idx_a, 0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy_a, 0);

    // Sub-threshold: 10+30=40, leak 40-5=35; stray start during busy ignored.
    run_a(4'b0101, 10, 20, 30, 40, 1'b0, 35, 6, 1'b1);
    // Fire: 35+160=195, leak 195-24=171 >= 100.
    run_a(4'b1111, 40, 40, 40, 40, 1'b1, 0, 6, 1'b1);
    // Two refractory timesteps.
    run_a(4'b1111, 127, 127, 127, 127, 1'b0, 0, 1, 1'b0);
    run_a(4'b1111, 127, 127, 127, 127, 1'b0, 0, 1, 1'b0);
    // 4*127=508, leak 508-63=445, fires.
    run_a(4'b1111, 127, 127, 127, 127, 1'b1, 0, 6, 1'b0);
    // Drain the refractory period again.
    run_a(4'b0000, 0, 0, 0, 0, 1'b0, 0, 1, 1'b0);
    run_a(4'b0000, 0, 0, 0, 0, 1'b0, 0, 1, 1'b0);

    // Negative saturation on the 9-bit instance: clamp at -256, leak to -224.
    e.spike = 1'b0;
    e.v     = -16'sd224;
    e.lat   = 6;
    @(negedge clk);
    for (int i = 0; i < 4; i++) w_b[i] = -8'sd128;
    spikes_b = 4'b1111;
    start_b  = 1'b1;
    q_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b_sat_2nd_add", $signed(vmem_b), -256);
    @(negedge clk);
    check("b_sat_3rd_add", $signed(vmem_b), -256);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done_b) seen = 1'b1;
      else @(negedge clk);
    end
    check("b_done_timeout", seen, 1);

    // Reset during INTEG cycle 3 aborts with no done.
    @(negedge clk);
    for (int i = 0; i < 4; i++) w_a[i] = 8'sd40;
    spikes_a = 4'b1111;
    start_a  = 1'b1;
    @(negedge clk);               // cycle 1
    start_a = 1'b0;
    @(negedge clk);               // cycle 2
    check("abort_vmem_pre", $signed(vmem_a), 40);
    @(negedge clk);               // cycle 3
    rst = 1'b1;
    @(negedge clk);
    check("abort_vmem", vmem_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_widx", w_idx_a, 0);
    rst = 1'b0;

    // A normal step afterwards matches the sub-threshold result.
    run_a(4'b0101, 10, 20, 30, 40, 1'b0, 35, 6, 1'b0);

    repeat (4) @(negedge clk);
    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit in case a wait is never satisfied.
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
